// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption: one shared inverse round reused for all ten rounds,
// with the closing AddRoundKey of round_key[0] folded into the plaintext register load.

module aes_inv_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then take the GF(2^8) inverse as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] r;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    r = b;
    for (int i = 0; i < 6; i++) begin
      r = gmul(r, r);
      r = gmul(r, b);
    end
    return gmul(r, r);
  endfunction

  logic [127:0] ark;
  logic [127:0] mixed;
  logic [127:0] pre;

  assign ark = state_in ^ round_key;

  for (genvar gi = 0; gi < 4; gi++) begin : g_imc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*gi -: 8];
    assign a1 = ark[119-32*gi -: 8];
    assign a2 = ark[111-32*gi -: 8];
    assign a3 = ark[103-32*gi -: 8];
    assign mixed[127-32*gi -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };
  end

  assign pre = last_round ? ark : mixed;

  // InvShiftRows moves row r right by r columns; InvSubBytes is bytewise so it commutes.
  for (genvar gi = 0; gi < 16; gi++) begin : g_isr_isb
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
    assign state_out[127-8*gi -: 8] = inv_sbox(pre[127-8*SRC -: 8]);
  end

endmodule

module aes_inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          ciphertext,
  input  logic [(NR+1)*128-1:0] round_keys,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          plaintext,
  output logic                  busy,
  output logic [3:0]            round_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [3:0]   step_reg, step_next;
  logic [127:0] plaintext_reg, plaintext_next;
  logic         out_valid_reg, out_valid_next;

  logic [127:0] key_arr [0:NR];
  logic [127:0] round_out;
  logic         last_round;

  for (genvar gi = 0; gi <= NR; gi++) begin : g_keys
    assign key_arr[gi] = round_keys[gi*128 +: 128];
  end

  assign busy       = (fsm_reg == RUN) || (fsm_reg == DONE);
  assign round_idx  = (fsm_reg == RUN) ? (NR_L - step_reg) : 4'd0;
  // The first step follows the initial AddRoundKey, so it has no InvMixColumns.
  assign last_round = (step_reg == 4'd0);
  assign out_valid  = out_valid_reg;
  assign plaintext  = plaintext_reg;

  aes_inv_round u_round (
    .state_in   (state_reg),
    .round_key  (key_arr[round_idx]),
    .last_round (last_round),
    .state_out  (round_out)
  );

  always_comb begin
    in_ready = 1'b0;
    if (rst_n && !abort) begin
      case (fsm_reg)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    step_next      = step_reg;
    plaintext_next = plaintext_reg;
    out_valid_next = out_valid_reg;
    case (fsm_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_next = ciphertext;
          step_next  = 4'd0;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        if (step_reg == NR_L - 4'd1) begin
          plaintext_next = round_out ^ key_arr[0];
          out_valid_next = 1'b1;
          fsm_next       = DONE;
        end else begin
          state_next = round_out;
          step_next  = step_reg + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          fsm_next       = IDLE;
          if (in_valid && in_ready) begin
            state_next = ciphertext;
            step_next  = 4'd0;
            fsm_next   = RUN;
          end
        end
      end
      default: fsm_next = IDLE;
    endcase
    if (abort) begin
      fsm_next       = IDLE;
      out_valid_next = 1'b0;
      step_next      = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      step_reg      <= '0;
      plaintext_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      step_reg      <= step_next;
      plaintext_reg <= plaintext_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl using the FIPS-197 C.1 AES-128 vector.

module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] GARBAGE = 128'hdeadbeefcafef00d0123456789abcdef;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   ciphertext;
  logic [1407:0]  round_keys;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   plaintext;
  logic           busy;
  logic [3:0]     round_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  aes_inv_cipher_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .round_keys (round_keys),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Offer a block at a negedge and hold it until the accepting posedge.
  task automatic send(input logic [127:0] ct);
    int n;
    n = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = ct;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ciphertext = GARBAGE;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {127'b0, out_valid}, 128'd1);
  endtask

  task automatic wait_round(input logic [3:0] idx);
    int n;
    n = 0;
    @(negedge clk);
    while (round_idx != idx && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_round", {124'b0, round_idx}, {124'b0, idx});
  endtask

  initial begin
    int t1;
    int t2;
    int ov_seen;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    ciphertext = '0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    round_keys = {
      128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h549932d1f08557681093ed9cbe2c974e,
      128'h47438735a41c65b9e016baf4aebf7ad2, 128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'h000102030405060708090a0b0c0d0e0f};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {127'b0, in_ready},  128'd0);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_plaintext", plaintext,           128'd0);
    check("rst_busy",      {127'b0, busy},      128'd0);
    check("rst_round_idx", {124'b0, round_idx}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

    // Single block: latency and round index sequence
    send(CT);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("single_round_idx", {124'b0, round_idx}, 128'(10 - k));
      check("single_ov_low",    {127'b0, out_valid}, 128'd0);
    end
    @(negedge clk);
    check("single_ov_high",   {127'b0, out_valid}, 128'd1);
    check("single_plaintext", plaintext,           PT);
    check("single_idx_done",  {124'b0, round_idx}, 128'd0);
    @(negedge clk);
    check("single_ov_clear", {127'b0, out_valid}, 128'd0);
    check("single_idle",     {127'b0, busy},      128'd0);

    // Back-to-back with DONE->RUN handoff
    @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = CT;
    wait_valid("b2b_first_valid");
    t1 = cyc;
    check("b2b_first_pt",    plaintext,          PT);
    check("b2b_handoff_rdy", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ciphertext = GARBAGE;
    wait_valid("b2b_second_valid");
    t2 = cyc;
    check("b2b_second_pt", plaintext,     PT);
    check("b2b_gap",       128'(t2 - t1), 128'd11);
    @(negedge clk);

    // Backpressure
    out_ready = 1'b0;
    send(CT);
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {127'b0, out_valid}, 128'd1);
      check("bp_hold_pt",    plaintext,           PT);
      check("bp_in_ready",   {127'b0, in_ready},  128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", {127'b0, in_ready}, 128'd1);
    @(negedge clk);
    check("bp_released", {127'b0, out_valid}, 128'd0);

    // Abort in IDLE blocks a simultaneous offer
    abort      = 1'b1;
    in_valid   = 1'b1;
    ciphertext = GARBAGE;
    #1;
    check("abort_idle_rdy", {127'b0, in_ready}, 128'd0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", {127'b0, busy}, 128'd0);

    // Abort mid-run
    send(CT);
    wait_round(4'd6);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy",      {127'b0, busy},      128'd0);
    check("abort_idx",       {124'b0, round_idx}, 128'd0);
    check("abort_in_ready",  {127'b0, in_ready},  128'd1);
    ov_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("abort_no_output", 128'(ov_seen), 128'd0);
    send(CT);
    wait_valid("abort_next_valid");
    check("abort_next_pt", plaintext, PT);
    @(negedge clk);

    // Reset mid-run at step 3
    send(CT);
    wait_round(4'd7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_out_valid", {127'b0, out_valid}, 128'd0);
    check("mrst_plaintext", plaintext,           128'd0);
    check("mrst_busy",      {127'b0, busy},      128'd0);
    check("mrst_idx",       {124'b0, round_idx}, 128'd0);
    check("mrst_in_ready",  {127'b0, in_ready},  128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_rdy_after", {127'b0, in_ready}, 128'd1);
    send(CT);
    wait_valid("mrst_next_valid");
    check("mrst_next_pt", plaintext, PT);
    @(negedge clk);

    // Garbage offered during RUN is ignored
    send(CT);
    repeat (3) @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = GARBAGE;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("ign_valid");
    check("ign_pt", plaintext, PT);
    @(negedge clk);
    check("ign_idle", {127'b0, busy}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
